// File: rtl/nithin574_uart_pkg.sv
// Shared types and constants for the Tiny Tapeout UART transmitter tile.
package nithin574_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic [7:0] UIO_OE_TX = 8'h0E;
    localparam int         TXD_BIT   = 1;
    localparam int         BUSY_BIT  = 2;
    localparam int         DONE_BIT  = 3;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/nithin574_uart_if.sv
// Tiny Tapeout user-module pin bundle; master is the host side, slave is the tile.
interface nithin574_uart_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/nithin574_baud_gen.sv
// Bit-period counter: tick is high on the last cycle of each CLKS_PER_BIT period.
module nithin574_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign tick = (!clear) && (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/tt_um_nithin574_uart_tx.sv
// 8N1 UART transmitter tile; define UART_TX_PARITY_EN to add an even-parity bit.
module tt_um_nithin574_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);
    import nithin574_uart_pkg::*;

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] uo_q, uo_d;
    logic [2:0] idx_q, idx_d;
    logic       start_q;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
`ifdef UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif
    logic       tick;
    logic       start_edge;
    logic       accept;
    logic       ins_unused;

    assign start_edge = uio_in[0] & ~start_q;
    assign accept     = start_edge && (state_q == ST_IDLE);
    assign ins_unused = &{1'b0, ena, uio_in[7:1]};

    nithin574_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state_q == ST_IDLE),
        .tick  (tick)
    );

    // Next state; output flops are loaded from the next state so they align with it.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        uo_d    = uo_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_START;
                    shift_d = ui_in;
                    uo_d    = ui_in;
                    idx_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                    par_d   = even_parity(ui_in);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d = par_d;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    // State and registered output flops, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= 8'h00;
            uo_q    <= 8'h00;
            idx_q   <= 3'd0;
            start_q <= 1'b0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            uo_q    <= uo_d;
            idx_q   <= idx_d;
            start_q <= uio_in[0];
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Pin mapping of the registered status bits.
    always_comb begin
        uio_out           = 8'h00;
        uio_out[TXD_BIT]  = txd_q;
        uio_out[BUSY_BIT] = busy_q;
        uio_out[DONE_BIT] = done_q;
    end

    assign uo_out = uo_q;
    assign uio_oe = UIO_OE_TX;

endmodule

// File: tb/tb_tt_um_nithin574_uart_tx.sv
// Directed bench for tt_um_nithin574_uart_tx at CLKS_PER_BIT = 4 (honours UART_TX_PARITY_EN).
module tb_tt_um_nithin574_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS = 11;
`else
    localparam int SLOTS = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    nithin574_uart_if bus ();

    tt_um_nithin574_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .ui_in   (bus.ui_in),
        .uo_out  (bus.uo_out),
        .uio_in  (bus.uio_in),
        .uio_out (bus.uio_out),
        .uio_oe  (bus.uio_oe),
        .ena     (bus.ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for frame slot s (0=start, 1..8=data, then parity/stop).
    function automatic logic slot_bit(input logic [7:0] d, input int s);
        if (s == 0) return 1'b0;
        if (s <= 8) return d[s-1];
        if (SLOTS == 11 && s == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic accept_byte(input logic [7:0] d);
        bus.ui_in     = d;
        bus.uio_in[0] = 1'b1;
        step();
        bus.uio_in[0] = 1'b0;
    endtask

    // Called just after the accept edge; returns in the done cycle.
    task automatic check_frame(input logic [7:0] d, input bit inject);
        for (int j = 0; j < SLOTS * CPB; j++) begin
            chk("txd",  32'(bus.uio_out[1]), 32'(slot_bit(d, j / CPB)));
            chk("busy", 32'(bus.uio_out[2]), 32'd1);
            chk("done", 32'(bus.uio_out[3]), 32'd0);
            chk("uo",   32'(bus.uo_out), 32'(d));
            if (inject && j == 3 * CPB) begin
                bus.ui_in     = 8'h3C;
                bus.uio_in[0] = 1'b1;
            end else if (inject && j == 3 * CPB + 1) begin
                bus.uio_in[0] = 1'b0;
            end
            step();
        end
        chk("done_pulse", 32'(bus.uio_out[3]), 32'd1);
        chk("done_busy",  32'(bus.uio_out[2]), 32'd0);
        chk("done_txd",   32'(bus.uio_out[1]), 32'd1);
    endtask

    initial begin
        bus.ena    = 1'b1;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        rst_n      = 1'b0;

        // Reset state
        step(); step(); step();
        chk("rst_txd",  32'(bus.uio_out[1]), 32'd1);
        chk("rst_busy", 32'(bus.uio_out[2]), 32'd0);
        chk("rst_done", 32'(bus.uio_out[3]), 32'd0);
        chk("rst_uo",   32'(bus.uo_out), 32'h00);
        chk("rst_oe",   32'(bus.uio_oe), 32'h0E);
        chk("rst_uio",  32'(bus.uio_out), 32'h02);
        rst_n = 1'b1;
        step();
        chk("idle_txd", 32'(bus.uio_out[1]), 32'd1);

        // Single frame 0xA5, single done pulse
        accept_byte(8'hA5);
        check_frame(8'hA5, 1'b0);
        step();
        chk("done_once", 32'(bus.uio_out[3]), 32'd0);
        chk("idle_after", 32'(bus.uio_out[1]), 32'd1);
        step();

        // Start edge during DATA is ignored
        accept_byte(8'hA5);
        check_frame(8'hA5, 1'b1);

        // Back-to-back: accept in the done cycle
        accept_byte(8'hFF);
        chk("b2b_done_clr", 32'(bus.uio_out[3]), 32'd0);
        check_frame(8'hFF, 1'b0);
        step();
        chk("b2b_uo", 32'(bus.uo_out), 32'hFF);

        // Reset during data bit 3 aborts without done
        accept_byte(8'h5A);
        for (int j = 0; j < 4 * CPB + 1; j++) step();
        chk("mid_busy", 32'(bus.uio_out[2]), 32'd1);
        chk("mid_bit3", 32'(bus.uio_out[1]), 32'd1);
        rst_n = 1'b0;
        step();
        chk("abort_txd",  32'(bus.uio_out[1]), 32'd1);
        chk("abort_busy", 32'(bus.uio_out[2]), 32'd0);
        chk("abort_done", 32'(bus.uio_out[3]), 32'd0);
        chk("abort_uo",   32'(bus.uo_out), 32'h00);
        rst_n = 1'b1;
        for (int j = 0; j < 12 * CPB; j++) begin
            step();
            chk("abort_no_done", 32'(bus.uio_out[3]), 32'd0);
            chk("abort_idle",    32'(bus.uio_out[1]), 32'd1);
        end

        // Start held high through reset release accepts 0x07 on first edge
        rst_n         = 1'b0;
        bus.ui_in     = 8'h07;
        bus.uio_in[0] = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        bus.uio_in[0] = 1'b0;
        chk("held_busy", 32'(bus.uio_out[2]), 32'd1);
        check_frame(8'h07, 1'b0);
        step();
        chk("held_done_once", 32'(bus.uio_out[3]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
